mul_div_unit: RTL and testbench
===============================

# mul_div_unit

Iterative multiply/divide unit in the EX stage, beside the combinational shifter and ALU. It takes the same 32-bit `src1`/`src2` operands and produces a 64-bit `{hi, lo}` result for MULT/MULTU/DIV/DIVU over 34 cycles. `hi`/`lo` are then read by MFHI/MFLO through the EX result mux. A start/busy/done handshake lets the hazard unit stall the pipeline while an operation is in flight.

## Interface
- `WIDTH`, 32, operand width; `hi`/`lo` are each `WIDTH` bits.
- `clk_i`  in  1  clock; all state updates on the rising edge.
- `rst_i`  in  1  reset: synchronous, active-high.
- `start`  in  1  request; sampled only when `busy`=0.
- `op`  in  2  operation: 00 MULTU, 01 MULT, 10 DIVU, 11 DIV.
- `src1`  in  WIDTH  multiplicand / dividend (rs).
- `src2`  in  WIDTH  multiplier / divisor (rt).
- `busy`  out  1  operation in progress; hazard unit stalls on `busy`.
- `done`  out  1  one-cycle pulse: `hi`/`lo` hold the new result.
- `hi`  out  WIDTH  MULT: upper product; DIV: remainder.
- `lo`  out  WIDTH  MULT: lower product; DIV: quotient.

## Operation
- **States:** IDLE, CALC, FIX, DONE.
- **IDLE/DONE → CALC** on `start`=1:
  - latch `op`;
  - latch |`src1`| and |`src2`| (magnitudes for signed ops, raw values for unsigned);
  - latch result signs: product sign = sign1^sign2; quotient sign = sign1^sign2; remainder sign = sign1;
  - clear the 5-bit iteration counter.
- **CALC:** one iteration per cycle, 32 cycles; counter 0..31; leave to FIX when the counter is 31.
  - Multiply: shift-add on a 64-bit accumulator; each cycle adds the multiplicand into the upper half if the accumulator LSB is 1, then shifts right 1 (33-bit add keeps the carry).
  - Divide: restoring division on a {remainder, quotient} 64-bit register; shift left 1, trial-subtract the divisor, set the quotient LSB when the difference is non-negative.
- **FIX:** apply two's-complement negation per the latched signs, write `hi`/`lo`, go to DONE.
- **DONE:** `done`=1 for exactly one cycle; `busy`=0. A `start` here is accepted (back-to-back operation); otherwise go to IDLE.
- **Divide by zero** (`src2`=0): no exception; full latency still taken; result `lo`=0xFFFFFFFF, `hi`=`src1` (unsigned and signed alike).
- **DIV 0x80000000 / 0xFFFFFFFF:** `lo`=0x80000000, `hi`=0; falls out naturally from the magnitude datapath.
- `start` while `busy`=1: ignored; operands and result are unaffected.
- `hi`/`lo` hold their value between operations; they change only at the FIX edge.

## Timing
- **Reset values:** state IDLE, `busy`=0, `done`=0, `hi`=0, `lo`=0, counter 0.
- **Reset mid-operation:** aborts at the next edge; all outputs return to reset values; no partial result is written.
- Let edge E0 be the edge that samples `start`=1:
  - `busy`=1 from after E0 through the FIX cycle (33 cycles);
  - `hi`/`lo` update at edge E33;
  - `done`=1 during the cycle after E33, with `busy`=0.
- **Latency:** start edge to result valid is 33 edges. Issue interval is 34 cycles when restarting from DONE.
- `rst_i` and `start` in the same cycle: reset wins.

## Structure
- **Shared package `mdu_pkg`:**
  - `op` encodings `OP_MULTU`/`OP_MULT`/`OP_DIVU`/`OP_DIV`;
  - state enum `mdu_state_t` (IDLE, CALC, FIX, DONE);
  - `MDU_ITERS`=32.
- **Sub-module `mdu_sign_fix`** (combinational): takes the raw 64-bit result plus the two sign flags and returns the corrected `{hi, lo}`; instantiated once, used in FIX.
- Single FSM plus one 64-bit datapath register, shared between multiply and divide.

## Test plan
- MULTU 0xFFFFFFFF × 0xFFFFFFFF → `hi`=0xFFFFFFFE, `lo`=0x00000001; `done` pulses exactly 34 cycles after the start edge's cycle.
- MULT 0xFFFFFFFD (−3) × 5 → `hi`=0xFFFFFFFF, `lo`=0xFFFFFFF1.
- DIV 0xFFFFFFF9 (−7) ÷ 2 → `lo`=0xFFFFFFFD, `hi`=0xFFFFFFFF; DIVU 7 ÷ 2 → `lo`=3, `hi`=1.
- Divide by zero: DIVU 0x12345678 ÷ 0 → `lo`=0xFFFFFFFF, `hi`=0x12345678. DIV 0x80000000 ÷ 0xFFFFFFFF → `lo`=0x80000000, `hi`=0.
- Second `start` (MULTU 2×3) pulsed during CALC → ignored; the first result is intact. Same `start` in the DONE cycle → accepted; `lo`=6 after 33 more edges.
- Assert `rst_i` at CALC iteration 10 → next cycle `busy`=0, `hi`=`lo`=0; no `done` pulse ever appears for the aborted operation.

Source files
------------

// File: rtl/mdu_pkg.sv
// mdu_pkg: shared encodings, state type and iteration count for the multiply/divide unit
package mdu_pkg;
    localparam logic [1:0] OP_MULTU = 2'b00;
    localparam logic [1:0] OP_MULT  = 2'b01;
    localparam logic [1:0] OP_DIVU  = 2'b10;
    localparam logic [1:0] OP_DIV   = 2'b11;
    localparam int MDU_ITERS = 32;
    typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} mdu_state_t;
endpackage

// File: rtl/mdu_sign_fix.sv
// mdu_sign_fix: applies result signs to the unsigned magnitude result
//   raw    : unsigned {hi, lo} from the iterative datapath
//   is_div : 1 = divide (hi/lo negated independently), 0 = multiply (64-bit negate)
//   neg_hi : negate remainder (divide only)
//   neg_lo : negate quotient (divide) / whole product (multiply)
//   res    : signed-corrected {hi, lo}
module mdu_sign_fix
    import mdu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [2*WIDTH-1:0] raw,
    input  logic               is_div,
    input  logic               neg_hi,
    input  logic               neg_lo,
    output logic [2*WIDTH-1:0] res
);
    logic [2*WIDTH-1:0] wide;
    logic [WIDTH-1:0]   hi_f, lo_f;
    always_comb begin
        wide = neg_lo ? -raw : raw;
        hi_f = neg_hi ? -raw[2*WIDTH-1:WIDTH] : raw[2*WIDTH-1:WIDTH];
        lo_f = neg_lo ? -raw[WIDTH-1:0] : raw[WIDTH-1:0];
        res  = is_div ? {hi_f, lo_f} : wide;
    end
endmodule

// File: rtl/mul_div_unit.sv
// mul_div_unit: iterative 32-cycle MULT/MULTU/DIV/DIVU producing {hi, lo}
//   clk_i, rst_i : clock, synchronous active-high reset
//   start, op    : request (taken when not busy) and operation select
//   src1, src2   : multiplicand/dividend, multiplier/divisor
//   busy, done   : in-flight flag for stalling, one-cycle result pulse
//   hi, lo       : product upper/lower, or remainder/quotient
module mul_div_unit
    import mdu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] src1,
    input  logic [WIDTH-1:0] src2,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);
    mdu_state_t         state;
    logic [4:0]         cnt;
    logic [2*WIDTH-1:0] acc;
    logic [WIDTH-1:0]   b;
    logic               is_div, neg_hi, neg_lo;
    logic               s1, s2;
    logic [WIDTH-1:0]   mag1, mag2;
    logic [WIDTH:0]     msum;
    logic [WIDTH+1:0]   dtrial;
    logic [2*WIDTH-1:0] acc_mul, acc_div, fixed;

    always_comb begin
        s1      = op[0] & src1[WIDTH-1];
        s2      = op[0] & src2[WIDTH-1];
        mag1    = s1 ? -src1 : src1;
        mag2    = s2 ? -src2 : src2;
        // shift-add: carry of the upper-half add becomes the new MSB after the right shift
        msum    = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, b} : '0);
        acc_mul = {msum, acc[WIDTH-1:1]};
        // restoring step: trial uses the 33-bit shifted remainder so a large remainder is not truncated
        dtrial  = {1'b0, acc[2*WIDTH-1:WIDTH-1]} - {2'b0, b};
        acc_div = dtrial[WIDTH+1] ? {acc[2*WIDTH-2:0], 1'b0}
                                  : {dtrial[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
        busy    = (state == CALC) || (state == FIX);
        done    = state == DONE;
    end

    mdu_sign_fix #(.WIDTH(WIDTH)) u_fix (
        .raw   (acc),
        .is_div(is_div),
        .neg_hi(neg_hi),
        .neg_lo(neg_lo),
        .res   (fixed)
    );

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state  <= IDLE;
            cnt    <= '0;
            acc    <= '0;
            b      <= '0;
            is_div <= 1'b0;
            neg_hi <= 1'b0;
            neg_lo <= 1'b0;
            hi     <= '0;
            lo     <= '0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        state  <= CALC;
                        cnt    <= '0;
                        is_div <= op[1];
                        acc    <= {{WIDTH{1'b0}}, mag1};
                        b      <= mag2;
                        neg_hi <= op[1] ? s1 : s1 ^ s2;
                        // divide-by-zero keeps the all-ones quotient unsigned and the dividend as remainder
                        neg_lo <= op[1] ? (s1 ^ s2) & (|src2) : s1 ^ s2;
                    end else begin
                        state <= IDLE;
                    end
                end
                CALC: begin
                    acc <= is_div ? acc_div : acc_mul;
                    cnt <= cnt + 5'd1;
                    if (cnt == 5'(MDU_ITERS - 1)) state <= FIX;
                end
                FIX: begin
                    hi    <= fixed[2*WIDTH-1:WIDTH];
                    lo    <= fixed[WIDTH-1:0];
                    state <= DONE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mul_div_unit.sv
// tb_mul_div_unit: directed scoreboard bench for mul_div_unit
module tb_mul_div_unit;
    logic        clk = 1'b0, rst_i = 1'b0, start = 1'b0;
    logic [1:0]  op = 2'b00;
    logic [31:0] src1 = '0, src2 = '0;
    logic        busy, done;
    logic [31:0] hi, lo;
    int          tests = 0, fails = 0, cyc = 0, t_send = 0;
    logic [63:0] sb[$];

    mul_div_unit #(.WIDTH(32)) dut (
        .clk_i(clk), .rst_i(rst_i), .start(start), .op(op),
        .src1(src1), .src2(src2), .busy(busy), .done(done), .hi(hi), .lo(lo)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // drive one start cycle from the current negedge; optionally record the expected result
    task automatic send(input logic [1:0] o, input logic [31:0] a, input logic [31:0] d,
                        input logic push, input logic [63:0] exp);
        op = o; src1 = a; src2 = d; start = 1'b1;
        t_send = cyc;
        if (push) sb.push_back(exp);
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_check(input string tag);
        int n = 0;
        logic [63:0] exp;
        while (!done && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk({tag, "_done"}, 64'(done), 64'd1);
        chk({tag, "_lat"}, 64'(cyc - t_send), 64'd34);
        if (sb.size() == 0) begin
            chk({tag, "_sb_empty"}, 64'(sb.size()), 64'd1);
        end else begin
            exp = sb.pop_front();
            chk({tag, "_hi"}, 64'(hi), 64'(exp[63:32]));
            chk({tag, "_lo"}, 64'(lo), 64'(exp[31:0]));
        end
    endtask

    initial begin
        logic [31:0] a, d;
        int pulses;
        rst_i = 1'b1;
        repeat (2) @(negedge clk);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_hi", 64'(hi), 64'd0);
        chk("rst_lo", 64'(lo), 64'd0);
        rst_i = 1'b0;
        @(negedge clk);

        send(2'b00, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 64'hFFFFFFFE_00000001);
        chk("multu_busy", 64'(busy), 64'd1);
        wait_check("multu_max");
        @(negedge clk);
        chk("done_one_cycle", 64'(done), 64'd0);
        chk("idle_busy", 64'(busy), 64'd0);

        send(2'b01, 32'hFFFFFFFD, 32'd5, 1'b1, 64'hFFFFFFFF_FFFFFFF1);
        wait_check("mult_neg");
        @(negedge clk);
        send(2'b01, 32'd7, 32'hFFFFFFFF, 1'b1, 64'hFFFFFFFF_FFFFFFF9);
        wait_check("mult_pos_neg");
        @(negedge clk);
        send(2'b11, 32'hFFFFFFF9, 32'd2, 1'b1, {32'hFFFFFFFF, 32'hFFFFFFFD});
        wait_check("div_neg");
        @(negedge clk);
        send(2'b10, 32'd7, 32'd2, 1'b1, {32'd1, 32'd3});
        wait_check("divu_7_2");
        @(negedge clk);
        send(2'b10, 32'h12345678, 32'd0, 1'b1, {32'h12345678, 32'hFFFFFFFF});
        wait_check("divu_zero");
        @(negedge clk);
        send(2'b11, 32'hFFFFFFF9, 32'd0, 1'b1, {32'hFFFFFFF9, 32'hFFFFFFFF});
        wait_check("div_zero_neg");
        @(negedge clk);
        send(2'b11, 32'h80000000, 32'hFFFFFFFF, 1'b1, {32'd0, 32'h80000000});
        wait_check("div_ovf");
        @(negedge clk);

        for (int i = 0; i < 3; i++) begin
            a = $urandom;
            d = $urandom | 32'h1;
            send(2'b00, a, d, 1'b1, 64'(a) * 64'(d));
            wait_check("multu_rand");
            @(negedge clk);
            send(2'b10, a, d >> 8, 1'b1, {a % (d >> 8), a / (d >> 8)});
            wait_check("divu_rand");
            @(negedge clk);
        end

        send(2'b10, 32'd100, 32'd7, 1'b1, {32'd2, 32'd14});
        repeat (5) @(negedge clk);
        op = 2'b00; src1 = 32'd2; src2 = 32'd3; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_check("ignored_start");
        send(2'b00, 32'd2, 32'd3, 1'b1, 64'd6);
        wait_check("back_to_back");
        @(negedge clk);

        send(2'b00, 32'h1234, 32'h5678, 1'b0, 64'd0);
        repeat (10) @(negedge clk);
        rst_i = 1'b1;
        @(negedge clk);
        rst_i = 1'b0;
        chk("abort_busy", 64'(busy), 64'd0);
        chk("abort_hi", 64'(hi), 64'd0);
        chk("abort_lo", 64'(lo), 64'd0);
        pulses = 0;
        repeat (50) begin
            @(negedge clk);
            if (done) pulses++;
        end
        chk("abort_no_done", 64'(pulses), 64'd0);

        rst_i = 1'b1; start = 1'b1; op = 2'b00; src1 = 32'd3; src2 = 32'd3;
        @(negedge clk);
        rst_i = 1'b0; start = 1'b0;
        chk("rst_beats_start", 64'(busy), 64'd0);
        chk("sb_drained", 64'(sb.size()), 64'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
